// File: rtl/deadtime_pkg.sv
// Shared types and constants for the dead-time insertion stage.
// Holds the leg state enum, the default counter width and the gate bit indices.
package deadtime_pkg;

   localparam int DT_W_DEFAULT = 8;

   // Bit positions inside each bridge's 4-bit gate vector.
   localparam int TR0 = 0;
   localparam int TR1 = 1;
   localparam int TR2 = 2;
   localparam int TR3 = 3;

   typedef enum logic [2:0] {
      LEG_OFF    = 3'd0,
      LEG_TOP    = 3'd1,
      LEG_BOT    = 3'd2,
      LEG_DT_TOP = 3'd3,
      LEG_DT_BOT = 3'd4
   } leg_state_t;

endpackage

// File: rtl/deadtime_leg.sv
// One half-bridge leg: state machine plus dead-interval counter.
// Drives a complementary top/bottom pair that never overlaps and never switches without a gap.
module deadtime_leg
   import deadtime_pkg::*;
#(
   parameter int DT_W = DT_W_DEFAULT
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            run,
   input  logic [DT_W-1:0] dt,
   input  logic            cmd,
   output logic            top,
   output logic            bot
);

   leg_state_t      state, nxt_state;
   logic [DT_W-1:0] cnt, nxt_cnt;
   logic            from_off, nxt_from_off;
   logic [DT_W-1:0] dt_eff;

   assign dt_eff = (dt == '0) ? DT_W'(1) : dt;

   always_comb begin
      nxt_state    = state;
      nxt_cnt      = cnt;
      nxt_from_off = from_off;
      if (!run) begin
         nxt_state = LEG_OFF;
         nxt_cnt   = '0;
      end else begin
         case (state)
            LEG_OFF: begin
               nxt_state    = cmd ? LEG_DT_TOP : LEG_DT_BOT;
               nxt_cnt      = dt_eff;
               nxt_from_off = 1'b1;
            end
            LEG_TOP: begin
               if (!cmd) begin
                  nxt_state    = LEG_DT_BOT;
                  nxt_cnt      = dt_eff;
                  nxt_from_off = 1'b0;
               end
            end
            LEG_BOT: begin
               if (cmd) begin
                  nxt_state    = LEG_DT_TOP;
                  nxt_cnt      = dt_eff;
                  nxt_from_off = 1'b0;
               end
            end
            // A reverted command returns straight to the gate we left; from OFF
            // there is no such gate, so the interval restarts the other way.
            LEG_DT_TOP: begin
               if (!cmd) begin
                  if (from_off) begin
                     nxt_state = LEG_DT_BOT;
                     nxt_cnt   = dt_eff;
                  end else begin
                     nxt_state = LEG_BOT;
                     nxt_cnt   = '0;
                  end
               end else if (cnt <= DT_W'(1)) begin
                  nxt_state = LEG_TOP;
                  nxt_cnt   = '0;
               end else begin
                  nxt_cnt = cnt - DT_W'(1);
               end
            end
            LEG_DT_BOT: begin
               if (cmd) begin
                  if (from_off) begin
                     nxt_state = LEG_DT_TOP;
                     nxt_cnt   = dt_eff;
                  end else begin
                     nxt_state = LEG_TOP;
                     nxt_cnt   = '0;
                  end
               end else if (cnt <= DT_W'(1)) begin
                  nxt_state = LEG_BOT;
                  nxt_cnt   = '0;
               end else begin
                  nxt_cnt = cnt - DT_W'(1);
               end
            end
            default: begin
               nxt_state = LEG_OFF;
               nxt_cnt   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= LEG_OFF;
         cnt      <= '0;
         from_off <= 1'b0;
         top      <= 1'b0;
         bot      <= 1'b0;
      end else begin
         state    <= nxt_state;
         cnt      <= nxt_cnt;
         from_off <= nxt_from_off;
         top      <= (nxt_state == LEG_TOP);
         bot      <= (nxt_state == LEG_BOT);
      end
   end

endmodule

// File: rtl/deadtime_gen.sv
// Dead-time generator for three H-bridges: fault latch, six leg FSMs, gate mapping.
// Define INPUT_SYNC_EN to pass cmd/trip/clr_fault through a two-flop stage (+2 cycles latency).
module deadtime_gen
   import deadtime_pkg::*;
#(
   parameter int DT_W = DT_W_DEFAULT
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   input  logic [DT_W-1:0] dt,
   input  logic [1:0]      cmd1,
   input  logic [1:0]      cmd2,
   input  logic [1:0]      cmd3,
   input  logic            trip,
   input  logic            clr_fault,
   output logic [3:0]      gate1,
   output logic [3:0]      gate2,
   output logic [3:0]      gate3,
   output logic            fault
);

   logic [5:0]  cmd_i;
   logic        trip_i;
   logic        clr_i;
   logic        fault_nxt;
   logic        run;
   logic [11:0] gate_all;

`ifdef INPUT_SYNC_EN
   logic [5:0] cmd_s1, cmd_s2;
   logic [1:0] ctl_s1, ctl_s2;

   always_ff @(posedge clk) begin
      if (rst) begin
         cmd_s1 <= '0;
         cmd_s2 <= '0;
         ctl_s1 <= '0;
         ctl_s2 <= '0;
      end else begin
         cmd_s1 <= {cmd3, cmd2, cmd1};
         cmd_s2 <= cmd_s1;
         ctl_s1 <= {clr_fault, trip};
         ctl_s2 <= ctl_s1;
      end
   end

   assign cmd_i  = cmd_s2;
   assign trip_i = ctl_s2[0];
   assign clr_i  = ctl_s2[1];
`else
   assign cmd_i  = {cmd3, cmd2, cmd1};
   assign trip_i = trip;
   assign clr_i  = clr_fault;
`endif

   // Legs look at the next fault value so a trip kills the gates on the same edge that latches it.
   assign fault_nxt = trip_i | (fault & ~clr_i);
   assign run       = en & ~fault_nxt;

   always_ff @(posedge clk) begin
      if (rst) begin
         fault <= 1'b0;
      end else begin
         fault <= fault_nxt;
      end
   end

   for (genvar b = 0; b < 3; b++) begin : g_bridge
      for (genvar l = 0; l < 2; l++) begin : g_leg
         deadtime_leg #(.DT_W(DT_W)) u_leg (
            .clk (clk),
            .rst (rst),
            .run (run),
            .dt  (dt),
            .cmd (cmd_i[2*b + l]),
            .top (gate_all[4*b + 2*l + TR0]),
            .bot (gate_all[4*b + 2*l + TR1])
         );
      end
   end

   assign gate1 = gate_all[TR3:TR0];
   assign gate2 = gate_all[4+TR3:4+TR0];
   assign gate3 = gate_all[8+TR3:8+TR0];

endmodule

// File: doc/deadtime_gen.md
# deadtime_gen

Dead-time insertion stage that sits directly downstream of the three-level phase-shifted modulator. It takes the six leg switching commands (two per H-bridge, three bridges) and produces the twelve complementary gate signals tr0..tr3 per bridge. Each top/bottom pair is separated by a programmable dead interval, and a latched trip input forces every gate off.

## Interface
Parameters:
- DT_W, 8: width of the dead-time count and per-leg counters.

Ports:
- clk  in  1  system clock (same clock as the modulator).
- rst  in  1  synchronous, active-high reset.
- en  in  1  gate enable; 0 forces all gates off.
- dt  in  DT_W  dead interval in clk cycles; 0 is treated as 1.
- cmd1, cmd2, cmd3  in  2 each  leg commands for bridges 1..3. Bit0 is the left leg (tr0/tr1), bit1 is the right leg (tr2/tr3). 1 = top on, 0 = bottom on.
- trip  in  1  external fault, level-sensitive.
- clr_fault  in  1  single-cycle pulse that clears the latched fault.
- gate1, gate2, gate3  out  4 each  gate drives for the bridges: [0]=tr0, [1]=tr1, [2]=tr2, [3]=tr3. Active-high, registered.
- fault  out  1  sticky fault flag, registered.

## Operation
- Six identical leg FSMs: bridge b, leg l drives gate_b[2l] (top) and gate_b[2l+1] (bottom).
- Leg states:
  - OFF: top=0, bottom=0.
  - TOP: top=1.
  - BOT: bottom=1.
  - DT_TOP: dead interval heading to top, both 0.
  - DT_BOT: dead interval heading to bottom, both 0.
- Leg transitions:
  - OFF → DT_TOP if cmd=1, else DT_BOT, when run=1 (run = en & ~fault).
  - TOP → DT_BOT when cmd=0.
  - BOT → DT_TOP when cmd=1.
  - DT_x → x when the counter reaches 1.
  - DT_TOP with cmd=0, entered from BOT → BOT next cycle (aborted transition). The mirror case DT_BOT with cmd=1, entered from TOP → TOP. An abort entered from OFF → the opposite DT state, with the counter reloaded.
  - Any state → OFF when run=0; OFF has priority over all other transitions.
- Counter load:
  - On entry to any DT state, counter ← max(dt,1).
  - dt is sampled only at entry; changes mid-interval have no effect on the running interval.
  - Counter decrements each cycle while in a DT state.
- Safety invariant: top and bottom of one leg are never 1 in the same cycle, and never in consecutive cycles without at least one both-off cycle between them.
- Fault:
  - trip=1 sets fault on the next edge.
  - While trip=1, fault stays set; clr_fault is ignored.
  - clr_fault=1 with trip=0 clears fault. If both trip and clr_fault are asserted, trip wins.
- Reset: all legs go to OFF, counters to 0, all gate outputs to 0, fault to 0.

## Timing
- cmd change sampled at edge n:
  - The old gate drops at edge n.
  - The new gate rises at edge n+max(dt,1).
- Example, dt=3: TOP→BOT gives both gates low for exactly 3 cycles.
- run falling at edge n: all gates 0 at edge n (one-cycle latency from the input).
- run rising at edge n: leg enters DT at n; first gate rises at n+max(dt,1). The dead interval always precedes the first turn-on.
- rst asserted mid-interval: outputs are 0 at the next edge, and the pending transition is discarded.
- Counters never wrap: dt at its maximum (2^DT_W−1) gives exactly that many dead cycles.

## Configuration
- INPUT_SYNC_EN defined:
  - cmd1..cmd3, trip and clr_fault each pass through a two-flop register stage before the FSMs.
  - All latencies above gain +2 cycles.
  - Sync flops reset to 0.
- Not defined: inputs feed the FSMs directly with the latencies stated in Timing.

## Structure
- Package deadtime_pkg holds:
  - the leg state enum (OFF, TOP, BOT, DT_TOP, DT_BOT);
  - the default DT_W;
  - the gate bit-index constants (TR0..TR3).
- Sub-module deadtime_leg: one leg FSM plus counter; inputs clk, rst, run, dt, cmd; outputs top, bot. Instantiated six times by the top level.
- Top level contains the fault latch, the optional sync stage and the port mapping.

## Test plan
- Reset, en=1, dt=4, cmd1=2'b01 steady → gate1[0] and gate1[3] rise 4 cycles after reset release; gate1[1] and gate1[2] stay 0.
- dt=3, cmd2[0] toggles 1→0 → gate2[0] falls at the sampling edge, gate2[1] rises exactly 3 cycles later, and there is no overlap cycle.
- dt=0, cmd3[1] toggles → one both-off cycle, then the opposite gate is on.
- dt=10, cmd1[0] 1→0 then back to 1 after 4 cycles (abort) → gate1[0] returns 1 cycle after the revert, and gate1[1] never asserts.
- trip pulsed mid-operation → all 12 gates 0 and fault=1 on the next edge. clr_fault with trip=1 is ignored. clr_fault with trip=0 clears fault, and gates restart after a full dt.
- Randomized cmd/dt/en for 10k cycles → checker confirms the safety invariant and minimum dead time on all six legs.
